// File: rtl/led_pattern_gen.sv
// LED pattern generator: static, blink, rotate-left and binary up-count
// modes, stepped by an internal prescaler. Load or mode change restarts the
// current mode from the stored pattern. All outputs are registered.
module led_pattern_gen #(
    parameter int                 WIDTH         = 8,
    parameter int                 PRESCALE      = 50_000_000,
    parameter logic [WIDTH-1:0]   RESET_PATTERN = 8'b10101010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pattern,
    input  logic             load,
    output logic [WIDTH-1:0] leds,
    output logic             tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_BLINK  = 2'd1,
        M_ROTATE = 2'd2,
        M_COUNT  = 2'd3
    } mode_t;

    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] r_leds;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_mode;
    logic             r_phase;   // 1 = blink ON
    logic             r_tick;

    logic             w_restart;
    logic [WIDTH-1:0] w_new_pat;
    logic             w_step;

    // Restart on load or a mode change; the step fires at the prescaler wrap
    always_comb begin
        w_restart = load || (mode != r_mode);
        w_new_pat = load ? pattern : r_pat;
        w_step    = en && (r_cnt == CNT_LAST);
    end

    // Pattern/prescaler state: reset > restart > step > count > hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pat   <= RESET_PATTERN;
            r_leds  <= RESET_PATTERN;
            r_cnt   <= '0;
            r_mode  <= mode;
            r_phase <= 1'b1;
            r_tick  <= 1'b0;
        end else if (w_restart) begin
            r_pat   <= w_new_pat;
            r_leds  <= w_new_pat;
            r_cnt   <= '0;
            r_mode  <= mode;
            r_phase <= 1'b1;
            r_tick  <= 1'b0;
        end else if (w_step) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            case (mode_t'(r_mode))
                M_STATIC: r_leds <= r_pat;
                M_BLINK: begin
                    // phase flips; coming back ON restores the pattern
                    r_phase <= ~r_phase;
                    r_leds  <= r_phase ? '0 : r_pat;
                end
                M_ROTATE: r_leds <= {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                M_COUNT:  r_leds <= r_leds + 1'b1;
                default:  r_leds <= r_leds;
            endcase
        end else if (en) begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign leds = r_leds;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (PRESCALE=4 and PRESCALE=1) share
// stimulus; each is compared every cycle against a model that derives the
// LED value from the stored pattern and the number of steps since restart.
module tb_led_pattern_gen;

    localparam int W = 8;
    localparam logic [W-1:0] RST_PAT = 8'hAA;
    localparam int PS [2] = '{4, 1};

    logic         clk = 1'b0;
    logic         rst, en, load;
    logic [1:0]   mode;
    logic [W-1:0] pattern;
    logic [W-1:0] leds [2];
    logic         tick [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    always #5 clk = ~clk;

    led_pattern_gen #(.WIDTH(W), .PRESCALE(4), .RESET_PATTERN(RST_PAT)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .pattern(pattern),
        .load(load), .leds(leds[0]), .tick(tick[0])
    );

    led_pattern_gen #(.WIDTH(W), .PRESCALE(1), .RESET_PATTERN(RST_PAT)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .pattern(pattern),
        .load(load), .leds(leds[1]), .tick(tick[1])
    );

    // ---- reference model: pattern, mode, enabled cycles since restart ----
    logic [W-1:0] m_pat  [2];
    logic [1:0]   m_mode [2];
    int           m_ec   [2];
    logic         m_tick [2];

    function automatic logic [W-1:0] exp_leds(input logic [1:0] md,
                                              input logic [W-1:0] p,
                                              input int k);
        int r;
        logic [W-1:0] v;
        case (md)
            2'd0: v = p;
            2'd1: v = (k % 2 == 1) ? '0 : p;
            2'd2: begin
                r = k % W;
                v = (r == 0) ? p : ((p << r) | (p >> (W - r)));
            end
            default: v = W'(int'(p) + k);
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_pat[i]  = RST_PAT;
                m_mode[i] = mode;
                m_ec[i]   = 0;
                m_tick[i] = 1'b0;
            end else if (load || mode != m_mode[i]) begin
                if (load) m_pat[i] = pattern;
                m_mode[i] = mode;
                m_ec[i]   = 0;
                m_tick[i] = 1'b0;
            end else if (en) begin
                m_ec[i]   = m_ec[i] + 1;
                m_tick[i] = (m_ec[i] % PS[i] == 0);
            end else begin
                m_tick[i] = 1'b0;
            end
        end
        if (!rst) armed = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // Outputs sampled on the falling edge, away from updates
    always @(negedge clk) begin
        if (armed) begin
            chk("leds_ps4", 32'(leds[0]), 32'(exp_leds(m_mode[0], m_pat[0], m_ec[0] / PS[0])));
            chk("tick_ps4", 32'(tick[0]), 32'(m_tick[0]));
            chk("leds_ps1", 32'(leds[1]), 32'(exp_leds(m_mode[1], m_pat[1], m_ec[1] / PS[1])));
            chk("tick_ps1", 32'(tick[1]), 32'(m_tick[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] md, input logic [W-1:0] p);
        mode = md; pattern = p; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        // reset overrides a simultaneous load
        rst = 1'b0; en = 1'b0; load = 1'b1; mode = 2'd1; pattern = 8'hFF;
        cyc(2);
        chk("rst_leds", 32'(leds[0]), 32'hAA);
        chk("rst_tick", 32'(tick[0]), 32'h0);
        rst = 1'b1; load = 1'b0; en = 1'b1;
        cyc(4);
        chk("blink_off", 32'(leds[0]), 32'h00);
        chk("blink_tick", 32'(tick[0]), 32'h1);
        cyc(4);
        chk("blink_on", 32'(leds[0]), 32'hAA);

        // rotate from 0x81
        do_load(2'd2, 8'h81);
        chk("rot_load", 32'(leds[0]), 32'h81);
        cyc(12);
        chk("rot_3", 32'(leds[0]), 32'h0C);

        // count wrap from 0xFE
        do_load(2'd3, 8'hFE);
        cyc(8);
        chk("cnt_wrap", 32'(leds[0]), 32'h00);
        cyc(4);
        chk("cnt_after", 32'(leds[0]), 32'h01);

        // load collides with the step edge in rotate mode
        do_load(2'd2, 8'h11);
        cyc(3);
        pattern = 8'h3C; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("coll_leds", 32'(leds[0]), 32'h3C);
        chk("coll_tick", 32'(tick[0]), 32'h0);
        cyc(4);
        chk("coll_next", 32'(leds[0]), 32'h78);

        // enable freeze in count mode, 2 cycles after a tick
        do_load(2'd3, 8'h10);
        cyc(6);
        en = 1'b0;
        cyc(10);
        chk("frz_leds", 32'(leds[0]), 32'h11);
        en = 1'b1;
        cyc(2);
        chk("frz_resume", 32'(leds[0]), 32'h12);

        // mode change 3 -> 2 restarts from pat_q, then mid-run reset
        mode = 2'd2;
        cyc(1);
        chk("mchg_leds", 32'(leds[0]), 32'h10);
        cyc(5);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        chk("rst2_leds", 32'(leds[0]), 32'hAA);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            en      = ($urandom_range(0, 7) != 0);
            load    = ($urandom_range(0, 15) == 0);
            pattern = W'($urandom);
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
            rst     = ($urandom_range(0, 199) != 0);
            cyc(1);
        end
        rst = 1'b1; load = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator driving the board LED bank from the top level. It replaces the fixed two-pattern LED driver with four selectable modes: static, blink, rotate and binary count. Each mode steps at a programmable rate derived from the system clock by an internal prescaler. It sits directly between the top-level control inputs (switches or a host register) and the LED pins.

## Interface
- WIDTH, 8, number of LEDs driven (≥2)
- PRESCALE, 50_000_000, clock cycles per pattern step (≥1); counter width is $clog2(PRESCALE), minimum 1
- RESET_PATTERN, 8'b10101010 (WIDTH bits), pattern register and LED value after reset
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset, sampled on rising clk
- en  input  1  1 = prescaler runs and pattern steps; 0 = freeze prescaler and LEDs
- mode  input  2  0 static, 1 blink, 2 rotate-left, 3 binary up-count
- pattern  input  WIDTH  value captured on load
- load  input  1  single-cycle strobe; captures pattern and restarts the current mode
- leds  output  WIDTH  registered LED drive
- tick  output  1  registered; high for one cycle on each pattern step

## Operation
- Internal state: pat_q (stored pattern), cnt (prescaler), mode_q (registered mode), phase (blink on/off), leds.
- Reset (rst=0 at an edge): pat_q=RESET_PATTERN, leds=RESET_PATTERN, cnt=0, tick=0, phase=ON, mode_q=mode. Reset overrides load, en and tick in the same cycle.
- Step condition: en=1 and cnt==PRESCALE-1. On a step cnt←0, tick←1, and leds advance per mode. Otherwise, when en=1, cnt←cnt+1 and tick←0.
- en=0: cnt, leds and phase hold; tick←0.
- Mode behaviour on a step:
  - static: leds←pat_q; no change.
  - blink: phase toggles; leds←pat_q when phase becomes ON, leds←0 when it becomes OFF.
  - rotate: leds←{leds[WIDTH-2:0], leds[WIDTH-1]}.
  - count: leds←leds+1, modulo 2^WIDTH; all-ones wraps to 0.
- Restart event, triggered by load=1 or by mode≠mode_q:
  - pat_q←pattern on load; otherwise pat_q is unchanged.
  - leds←new pat_q, phase←ON, cnt←0, tick←0, mode_q←mode.
  - Count mode therefore starts from the loaded value. Rotate mode starts from the loaded pattern.
- Priority, highest first: reset > restart (load or mode change) > step > hold. A load coinciding with a step suppresses that step. No tick is emitted in that cycle.
- Restart applies regardless of en. With en=0 the LEDs show the new pattern and then hold.

## Timing
- All outputs are registered, so there is no combinational path from any input to leds or tick.
- Load or mode change sampled at edge N: leds reflect the new pattern and tick=0 from edge N.
- After a restart with en held at 1, the first step occurs PRESCALE edges later. Steps then repeat every PRESCALE cycles.
- tick and the leds update become visible at the same edge; tick lasts exactly one cycle.
- PRESCALE=1: a step occurs on every enabled cycle, so tick stays high continuously while en=1 and no restart occurs.
- Deasserting en mid-count preserves cnt. Reasserting en resumes the count where it stopped, with no lost or extra step.

## Test plan
- Reset, blink, release (WIDTH=8, PRESCALE=4): hold rst=0 for 2 cycles with load=1 and pattern=0xFF -> leds=0xAA, tick=0. Release rst with en=1 and mode=1 -> first tick 4 cycles later, leds=0x00; next tick leds=0xAA.
- Rotate: load pattern=0x81 with mode=2 and en=1 -> leds=0x81, then 0x03, 0x06, 0x0C on successive ticks, 4 cycles apart.
- Count wrap: load 0xFE with mode=3 -> leds=0xFE, 0xFF, 0x00, 0x01 on successive ticks.
- Load/step collision: assert load with pattern=0x3C on the exact cycle cnt==3 in rotate mode -> no tick, leds=0x3C, next tick 4 cycles later gives leds=0x78.
- Enable freeze: in count mode, drop en for 10 cycles 2 cycles after a tick -> leds and tick frozen. Re-enable -> next tick exactly 2 enabled cycles later.
- Mode change and mid-run reset: switch mode 3→2 -> leds return to pat_q at that edge and cnt restarts. Then pulse rst=0 for 1 cycle -> leds=0xAA and tick=0 at the next edge.
